// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: square-wave clk_out plus one-cycle tick strobe.
// The half-period terminal count reloads through a one-deep valid/ready slot.
module clock_divider_prog #(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = 99999999
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] pending;
  logic             pending_full;

  assign div_ready = ~pending_full;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      counter      <= '0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
      cur_div      <= RESET_DIV;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      // Capture and apply are mutually exclusive on pending_full, so a value
      // captured at a terminal edge always waits for the following terminal.
      if (div_valid && !pending_full) begin
        pending      <= div_in;
        pending_full <= 1'b1;
      end

      if (clear) begin
        counter <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (!enable) begin
        tick <= 1'b0;
        if (pending_full) begin
          cur_div      <= pending;
          pending_full <= 1'b0;
          counter      <= '0;
        end
      end else if (counter >= cur_div) begin
        counter <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
        if (pending_full) begin
          cur_div      <= pending;
          pending_full <= 1'b0;
        end
      end else begin
        counter <= counter + 1'b1;
        tick    <= 1'b0;
      end
    end
  end

endmodule
